mult_arbiter: RTL

Two-client round-robin arbiter and sequencer for the shared `multiplier` block. It collects operand pairs from two requesters and issues one operation at a time over the multiplier's `req`/`rdy`/`done` handshake. It returns the product to the client that owns the operation. It sits between the client logic and a single `multiplier` instance and replaces direct client-to-multiplier wiring.

---
 rtl/mult_arbiter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/mult_arbiter.sv
// Two-client round-robin arbiter that sequences operations onto one shared
// multiplier over its req/rdy/done handshake and routes each product back to its owner.
module mult_arbiter #(
  parameter int WIDTH   = 5,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               c0_req,
  input  logic [WIDTH-1:0]   c0_a,
  input  logic [WIDTH-1:0]   c0_b,
  output logic               c0_gnt,
  output logic               c0_done,
  output logic [2*WIDTH-1:0] c0_ab,
  input  logic               c1_req,
  input  logic [WIDTH-1:0]   c1_a,
  input  logic [WIDTH-1:0]   c1_b,
  output logic               c1_gnt,
  output logic               c1_done,
  output logic [2*WIDTH-1:0] c1_ab,
  output logic               m_req,
  output logic [WIDTH-1:0]   m_a,
  output logic [WIDTH-1:0]   m_b,
  input  logic               m_rdy,
  input  logic               m_done,
  input  logic [2*WIDTH-1:0] m_ab,
  output logic               busy,
  output logic               err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   last_q, last_d;
  logic   owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic               m_req_q, m_req_d;
  logic [WIDTH-1:0]   m_a_q, m_a_d;
  logic [WIDTH-1:0]   m_b_q, m_b_d;
  logic               c0_gnt_q, c0_gnt_d;
  logic               c1_gnt_q, c1_gnt_d;
  logic               c0_done_q, c0_done_d;
  logic               c1_done_q, c1_done_d;
  logic [2*WIDTH-1:0] c0_ab_q, c0_ab_d;
  logic [2*WIDTH-1:0] c1_ab_q, c1_ab_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;

  logic any_req;
  logic win;
  logic timeout_hit;

  // On a tie the client that was not served last wins.
  assign any_req     = c0_req | c1_req;
  assign win         = (c0_req && c1_req) ? ~last_q : c1_req;
  // cnt_q is 0 in the first WAIT cycle, so the abort edge falls TIMEOUT cycles later.
  assign timeout_hit = (cnt_q == CNT_LIMIT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      owner_q   <= 1'b0;
      cnt_q     <= '0;
      m_req_q   <= 1'b0;
      m_a_q     <= '0;
      m_b_q     <= '0;
      c0_gnt_q  <= 1'b0;
      c1_gnt_q  <= 1'b0;
      c0_done_q <= 1'b0;
      c1_done_q <= 1'b0;
      c0_ab_q   <= '0;
      c1_ab_q   <= '0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      m_req_q   <= m_req_d;
      m_a_q     <= m_a_d;
      m_b_q     <= m_b_d;
      c0_gnt_q  <= c0_gnt_d;
      c1_gnt_q  <= c1_gnt_d;
      c0_done_q <= c0_done_d;
      c1_done_q <= c1_done_d;
      c0_ab_q   <= c0_ab_d;
      c1_ab_q   <= c1_ab_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    cnt_d   = '0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = ISSUE;
          owner_d = win;
        end
      end
      ISSUE: begin
        if (m_req_q && m_rdy) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (m_done || timeout_hit) begin
          state_d = IDLE;
          last_d  = owner_q;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_req_d   = (state_d == ISSUE);
    busy_d    = (state_d != IDLE);
    m_a_d     = m_a_q;
    m_b_d     = m_b_q;
    c0_gnt_d  = 1'b0;
    c1_gnt_d  = 1'b0;
    c0_done_d = 1'b0;
    c1_done_d = 1'b0;
    c0_ab_d   = c0_ab_q;
    c1_ab_d   = c1_ab_q;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          c0_gnt_d = ~win;
          c1_gnt_d = win;
          m_a_d    = win ? c1_a : c0_a;
          m_b_d    = win ? c1_b : c0_b;
        end
      end
      WAIT: begin
        if (m_done) begin
          if (owner_q) begin
            c1_done_d = 1'b1;
            c1_ab_d   = m_ab;
          end else begin
            c0_done_d = 1'b1;
            c0_ab_d   = m_ab;
          end
        end else if (timeout_hit) begin
          err_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign m_req   = m_req_q;
  assign m_a     = m_a_q;
  assign m_b     = m_b_q;
  assign c0_gnt  = c0_gnt_q;
  assign c1_gnt  = c1_gnt_q;
  assign c0_done = c0_done_q;
  assign c1_done = c1_done_q;
  assign c0_ab   = c0_ab_q;
  assign c1_ab   = c1_ab_q;
  assign busy    = busy_q;
  assign err     = err_q;

endmodule
